// File: rtl/avm_master_arbiter.sv
// Two-port Avalon-MM master arbiter sharing one UART slave port.
// Optional stall abort enabled by defining AVM_ARB_TIMEOUT_EN.
module avm_master_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_waitrequest,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_waitrequest,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t state;
    logic   last_r;
    logic   pend0;
    logic   pend1;
    logic   sel1;
    logic   abort;
    logic   own0;
    logic   own1;

    assign pend0 = r0_read | r0_write;
    assign pend1 = r1_read | r1_write;
    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign sel1  = pend1 & (~pend0 | ~last_r);

`ifdef AVM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt;
    assign abort = (state == S_BUSY) & avm_waitrequest &
                   (cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign abort = 1'b0;
`endif

    // Arbitration FSM with registered master-side outputs.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state         <= S_IDLE;
            last_r        <= 1'b1;
            o_grant       <= 2'b00;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
`ifdef AVM_ARB_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend0 | pend1) begin
                        state   <= S_BUSY;
                        last_r  <= sel1;
                        o_grant <= sel1 ? 2'b10 : 2'b01;
                        if (sel1) begin
                            avm_address   <= r1_address;
                            avm_writedata <= r1_writedata;
                            avm_write     <= r1_write;
                            avm_read      <= r1_read & ~r1_write;
                        end else begin
                            avm_address   <= r0_address;
                            avm_writedata <= r0_writedata;
                            avm_write     <= r0_write;
                            avm_read      <= r0_read & ~r0_write;
                        end
`ifdef AVM_ARB_TIMEOUT_EN
                        cnt <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (!avm_waitrequest || abort) begin
                        state     <= S_IDLE;
                        o_grant   <= 2'b00;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                    end
`ifdef AVM_ARB_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign own0 = (state == S_BUSY) & o_grant[0];
    assign own1 = (state == S_BUSY) & o_grant[1];

    // Slave response routed combinationally to the current owner only.
    always_comb begin
        r0_waitrequest = own0 ? (avm_waitrequest & ~abort) : 1'b1;
        r1_waitrequest = own1 ? (avm_waitrequest & ~abort) : 1'b1;
        r0_readdata    = (own0 & ~abort) ? avm_readdata : '0;
        r1_readdata    = (own1 & ~abort) ? avm_readdata : '0;
    end

    assign o_timeout = abort;

endmodule

// File: tb/tb_avm_master_arbiter.sv
// Bench for avm_master_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_avm_master_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef AVM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          avm_rst;
    logic [AW-1:0] r0_address, r1_address;
    logic          r0_read, r0_write, r1_read, r1_write;
    logic [DW-1:0] r0_writedata, r1_writedata;
    logic [DW-1:0] r0_readdata, r1_readdata;
    logic          r0_waitrequest, r1_waitrequest;
    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;
    logic [1:0]    o_grant;
    logic          o_timeout;

    always #5 clk = ~clk;

    avm_master_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .avm_clk(clk), .avm_rst(avm_rst),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
        .r0_writedata(r0_writedata), .r0_readdata(r0_readdata),
        .r0_waitrequest(r0_waitrequest),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
        .r1_writedata(r1_writedata), .r1_readdata(r1_readdata),
        .r1_waitrequest(r1_waitrequest),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    int n_vec = 0;
    int n_mis = 0;
    int to_seen = 0;

    // Reference model: current transaction (if any) and who went last.
    bit            m_busy  = 0;
    int            m_own   = 0;
    bit            m_last  = 1;
    bit            m_fresh = 1;
    bit            m_rd    = 0;
    bit            m_wr    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_abort();
        return TO_EN && m_busy && avm_waitrequest && (m_stall == TO - 1);
    endfunction

    task automatic step();
        bit ab;
        bit o0;
        bit o1;
        bit p0;
        bit p1;
        int w;
        @(negedge clk);
        #2;
        ab = m_abort();
        o0 = m_busy && m_own == 0;
        o1 = m_busy && m_own == 1;
        chk("grant", o_grant, m_busy ? (m_own == 1 ? 2 : 1) : 0);
        chk("avm_read", avm_read, m_busy && m_rd);
        chk("avm_write", avm_write, m_busy && m_wr);
        if (m_busy || m_fresh) begin
            chk("avm_address", avm_address, m_addr);
            chk("avm_writedata", avm_writedata, m_wdata);
        end
        chk("r0_wait", r0_waitrequest, o0 ? (avm_waitrequest && !ab) : 1);
        chk("r1_wait", r1_waitrequest, o1 ? (avm_waitrequest && !ab) : 1);
        chk("r0_rdata", r0_readdata, (o0 && !ab) ? avm_readdata : 0);
        chk("r1_rdata", r1_readdata, (o1 && !ab) ? avm_readdata : 0);
        chk("timeout", o_timeout, ab);
        if (o_timeout === 1'b1) to_seen++;
        @(posedge clk);
        if (avm_rst) begin
            m_busy = 0; m_last = 1; m_fresh = 1;
            m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        end else if (!m_busy) begin
            p0 = r0_read || r0_write;
            p1 = r1_read || r1_write;
            if (p0 || p1) begin
                w = (p0 && p1) ? (m_last ? 0 : 1) : (p1 ? 1 : 0);
                m_busy = 1; m_own = w; m_last = (w == 1);
                m_fresh = 0; m_stall = 0;
                m_addr  = w ? r1_address : r0_address;
                m_wdata = w ? r1_writedata : r0_writedata;
                m_wr    = w ? r1_write : r0_write;
                m_rd    = w ? (r1_read && !r1_write) : (r0_read && !r0_write);
            end
        end else if (!avm_waitrequest || ab) begin
            m_busy = 0;
        end else begin
            m_stall++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
        r0_address = '0; r1_address = '0;
        r0_writedata = '0; r1_writedata = '0;
        avm_waitrequest = 0; avm_readdata = '0;
    endtask

    initial begin
        idle_inputs();
        avm_rst = 1;
        step(); step();
        avm_rst = 0;
        step();

        // Single read from r0, slave stalls 3 cycles then returns 0x80.
        r0_read = 1; r0_address = 5'd8; avm_waitrequest = 1;
        step();
        chk("sr_grant", o_grant, 2'b01);
        chk("sr_read", avm_read, 1);
        for (int i = 0; i < 3; i++) step();
        avm_waitrequest = 0; avm_readdata = 32'h80;
        step();
        r0_read = 0; avm_readdata = '0;
        step(); step();

        // Simultaneous requests after reset; strobes held high.
        avm_rst = 1; step(); avm_rst = 0;
        r0_read = 1; r1_read = 1; r0_address = 5'd0; r1_address = 5'd8;
        avm_readdata = 32'h1234;
        step();
        chk("tie_first", o_grant, 2'b01);
        for (int i = 0; i < 8; i++) step();
        r0_read = 0; r1_read = 0;
        step(); step();

        // Write capture: r1 changes writedata while slave stalls.
        r1_write = 1; r1_address = 5'd4; r1_writedata = 32'hA5;
        avm_waitrequest = 1;
        step();
        r1_writedata = 32'hFF; r1_address = 5'd0;
        for (int i = 0; i < 3; i++) step();
        chk("wc_wdata", avm_writedata, 32'hA5);
        chk("wc_addr", avm_address, 5'd4);
        avm_waitrequest = 0;
        step();
        r1_write = 0;
        step();

        // Both strobes from r0: only the write goes out.
        r0_read = 1; r0_write = 1; r0_address = 5'd4;
        r0_writedata = 32'h5A; avm_waitrequest = 1;
        step();
        chk("both_wr", avm_write, 1);
        chk("both_rd", avm_read, 0);
        avm_waitrequest = 0;
        step();
        r0_read = 0; r0_write = 0;
        step();

        // Reset during a stalled transfer, then a tie.
        r1_read = 1; r1_address = 5'd0; avm_waitrequest = 1;
        step(); step(); step();
        avm_rst = 1;
        step();
        avm_rst = 0;
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_rd", avm_read, 0);
        r0_read = 1;
        step();
        chk("rst_tie", o_grant, 2'b01);
        avm_waitrequest = 0;
        step();
        r0_read = 0; r1_read = 0;
        step(); step();

        // Slave stalls forever.
        to_seen = 0;
        r0_read = 1; r0_address = 5'd8; avm_waitrequest = 1;
        avm_readdata = 32'hDEAD;
        step();
        r0_read = 0;
        for (int i = 0; i < 24; i++) step();
        chk("to_pulses", to_seen, TO_EN ? 1 : 0);
        avm_rst = 1; step(); avm_rst = 0;
        idle_inputs();
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            avm_rst = ($urandom_range(0, 59) == 0);
            r0_read  = $urandom_range(0, 2) == 0;
            r0_write = $urandom_range(0, 3) == 0;
            r1_read  = $urandom_range(0, 2) == 0;
            r1_write = $urandom_range(0, 3) == 0;
            r0_address = AW'($urandom_range(0, 2) * 4);
            r1_address = AW'($urandom_range(0, 2) * 4);
            r0_writedata = $urandom;
            r1_writedata = $urandom;
            avm_waitrequest = $urandom_range(0, 2) != 0;
            avm_readdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
